// File: rtl/logic16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic16_arbiter
// Purpose  : Shares one WIDTH-bit bitwise logic unit (NOT/AND/OR/XOR) between
//            NREQ requesters. Requests use valid/ready channels and are served
//            one at a time. The result comes back on a single response
//            channel, tagged with the index of the requester that issued it.
// Options  : LOGIC16_FIXED_PRIORITY_EN - when defined, the lowest requesting
//            index always wins and the round-robin pointer is removed.
//            When undefined (default), arbitration is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module logic16_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);

    // Opcode encoding of the shared logic unit
    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDW-1:0]     id_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [WIDTH-1:0]   result_d;

`ifndef LOGIC16_FIXED_PRIORITY_EN
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
`endif

    // Per-requester views of the packed request buses
    logic [1:0]         op_arr [NREQ];
    logic [WIDTH-1:0]   a_arr  [NREQ];
    logic [WIDTH-1:0]   b_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[2*i +: 2];
        assign a_arr[i]  = req_a[WIDTH*i +: WIDTH];
        assign b_arr[i]  = req_b[WIDTH*i +: WIDTH];
    end

    // Grant search: first requesting index in scan order
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     scan_idx;
    int                 scan;

    // Scan requesters starting at the pointer (or at 0 for fixed priority)
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef LOGIC16_FIXED_PRIORITY_EN
            scan = k;
`else
            scan = int'(ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
`endif
            scan_idx = scan[IDW-1:0];
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // One-hot accept, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!reset && (state_q == S_IDLE) && grant_found &&
                (grant_idx == i[IDW-1:0])) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Shared bitwise logic unit operating on the latched operands
    always_comb begin
        result_d = '0;
        case (op_q)
            OP_NOT:  result_d = ~a_q;
            OP_AND:  result_d = a_q & b_q;
            OP_OR:   result_d = a_q | b_q;
            OP_XOR:  result_d = a_q ^ b_q;
            default: result_d = '0;
        endcase
    end

`ifndef LOGIC16_FIXED_PRIORITY_EN
    // Next round-robin start point: the requester after the one just served
    always_comb begin
        ptr_d = '0;
        if (id_q != IDW'(NREQ - 1)) begin
            ptr_d = id_q + 1'b1;
        end
    end
`endif

    // Control FSM: accept in IDLE, compute in EXEC, hold result in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifndef LOGIC16_FIXED_PRIORITY_EN
            ptr_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // grant_found implies req_valid and req_ready at grant_idx
                    if (grant_found) begin
                        op_q    <= op_arr[grant_idx];
                        a_q     <= a_arr[grant_idx];
                        b_q     <= b_arr[grant_idx];
                        id_q    <= grant_idx;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= result_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
`ifndef LOGIC16_FIXED_PRIORITY_EN
                        ptr_q       <= ptr_d;
`endif
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logic16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic16_arbiter
// Purpose  : Directed self-checking bench for logic16_arbiter. Expected
//            responses are queued when a request is presented and compared
//            when the response channel shows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic16_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        busy;

    logic [1:0]  op_t [4];
    logic [15:0] a_t  [4];
    logic [15:0] b_t  [4];

    assign req_op = {op_t[3], op_t[2], op_t[1], op_t[0]};
    assign req_a  = {a_t[3], a_t[2], a_t[1], a_t[0]};
    assign req_b  = {b_t[3], b_t[2], b_t[1], b_t[0]};

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    int n_checks = 0;
    int n_pass   = 0;

    logic16_arbiter #(.NREQ(4), .IDW(2), .WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare against the response channel
    task automatic pop_compare(input string tag);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            last_exp = sb.pop_front();
            check({tag, "_rsp_id"},   32'(rsp_id),   32'(last_exp.id));
            check({tag, "_rsp_data"}, 32'(rsp_data), 32'(last_exp.data));
        end
    endtask

    // Present-and-complete one operation expected to be granted to g
    task automatic transact(input string tag, input int g);
        exp_t e;
        check({tag, "_ready"}, 32'(req_ready), 32'd1 << g);
        e.id   = 2'(g);
        e.data = alu(op_t[g], a_t[g], b_t[g]);
        sb.push_back(e);
        tick();
        check({tag, "_exec_busy"},  32'(busy), 32'd1);
        check({tag, "_exec_vld"},   32'(rsp_valid), 32'd0);
        check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, "_rsp_vld"}, 32'(rsp_valid), 32'd1);
        pop_compare(tag);
        if (rsp_ready) begin
            tick();
            check({tag, "_done_busy"}, 32'(busy), 32'd0);
            check({tag, "_done_vld"},  32'(rsp_valid), 32'd0);
        end
    endtask

    int rr_seq [5];

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_t[i] = 2'b00;
            a_t[i]  = 16'h0000;
            b_t[i]  = 16'h0000;
        end
`ifdef LOGIC16_FIXED_PRIORITY_EN
        rr_seq = '{0, 0, 0, 0, 0};
`else
        rr_seq = '{0, 1, 2, 3, 0};
`endif

        // Reset: accept is blocked even with all requests pending
        tick();
        tick();
        check("rst_ready_forced", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        reset     = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_ready_idle", 32'(req_ready), 32'd0);
        tick();

        // Single NOT request from requester 0
        op_t[0]   = 2'b00;
        a_t[0]    = 16'h00FF;
        req_valid = 4'b0001;
        #1;
        transact("single", 0);
        check("single_value", 32'(last_exp.data), 32'h0000_FF00);
        req_valid = 4'b0000;

        // Every opcode from requester 2
        a_t[2] = 16'hF0F0;
        b_t[2] = 16'h3C3C;
        req_valid = 4'b0100;
        op_t[2] = 2'b01; #1; transact("and2", 2);
        op_t[2] = 2'b10; #1; transact("or2",  2);
        op_t[2] = 2'b11; #1; transact("xor2", 2);
        op_t[2] = 2'b00; #1; transact("not2", 2);
        req_valid = 4'b0000;

        // Round-robin with all requesters asserting from a fresh pointer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_t[i] = 2'(i);
            a_t[i]  = 16'h1234 + 16'(i * 16'h1111);
            b_t[i]  = 16'hA5C3 ^ 16'(i * 16'h0F0F);
        end
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            transact($sformatf("rr%0d", k), rr_seq[k]);
        end
        req_valid = 4'b0000;
        #1;

        // Backpressure: result held while the consumer stalls
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        transact("bp", 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_vld%0d", c),   32'(rsp_valid), 32'd1);
            check($sformatf("bp_data%0d", c),  32'(rsp_data),  32'(last_exp.data));
            check($sformatf("bp_id%0d", c),    32'(rsp_id),    32'(last_exp.id));
            check($sformatf("bp_ready%0d", c), 32'(req_ready), 32'd0);
            check($sformatf("bp_busy%0d", c),  32'(busy),      32'd1);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        tick();
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_vld",  32'(rsp_valid), 32'd0);

        // Withdrawn request: requester 1 asks only while the FSM is in RESP
        rsp_ready = 1'b0;
        op_t[3]   = 2'b11;
        a_t[3]    = 16'hBEEF;
        b_t[3]    = 16'h1357;
        req_valid = 4'b1000;
        #1;
        transact("wd_issue", 3);
        req_valid = 4'b0010;
        #1;
        check("wd_ready_resp", 32'(req_ready), 32'd0);
        tick();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        #1;
        check("wd_ready_dropped", 32'(req_ready), 32'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("wd_idle_ready%0d", c), 32'(req_ready), 32'd0);
            check($sformatf("wd_idle_busy%0d", c),  32'(busy),      32'd0);
            tick();
        end

        // Reset during EXEC discards the operation
        op_t[1]   = 2'b01;
        a_t[1]    = 16'hFFFF;
        b_t[1]    = 16'h5AA5;
        req_valid = 4'b0010;
        #1;
        check("mid_ready", 32'(req_ready), 32'b0010);
        tick();
        check("mid_exec_busy", 32'(busy), 32'd1);
        reset     = 1'b1;
        req_valid = 4'b0100;
        op_t[2]   = 2'b10;
        a_t[2]    = 16'h0F00;
        b_t[2]    = 16'h00F0;
        #1;
        check("mid_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rsp_data",  32'(rsp_data),  32'd0);
        check("mid_rsp_id",    32'(rsp_id),    32'd0);
        check("mid_busy",      32'(busy),      32'd0);
        reset = 1'b0;
        sb.delete();
        #1;
        transact("post_rst", 2);
        req_valid = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
